// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared state encoding, trap codes and ebreak constant for halt_ctrl
package npc_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    S_RUN    = ST_RUN,
    S_DRAIN  = ST_DRAIN,
    S_HALTED = ST_HALTED
  } state_t;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_GOOD    = 2'b01;
  localparam logic [1:0] TRAP_BAD     = 2'b10;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b11;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  // A bad flag always wins; otherwise an ebreak reports pass/fail through a0.
  function automatic logic [1:0] trap_classify(input logic bad, input logic [31:0] a0);
    if (bad)
      return TRAP_BAD;
    else if (a0 == 32'd0)
      return TRAP_GOOD;
    else
      return TRAP_BAD;
  endfunction

endpackage

// File: rtl/wdog_cnt.sv
// rtl/wdog_cnt.sv - clearable, enabled watchdog with terminal-count expire
module wdog_cnt #(
  parameter logic [31:0] LIMIT = 32'd4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [31:0] cnt;

  // A clear in the terminal cycle suppresses the expire.
  assign expire = en && !clr && (cnt == LIMIT - 32'd1);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 32'd0;
    else if (en) begin
      if (clr || expire)
        cnt <= 32'd0;
      else
        cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// rtl/halt_ctrl.sv - retire monitor that traps on ebreak/bad/timeout, drains, then halts
module halt_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] WDOG_LIMIT   = 32'd4096,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_valid,
  input  logic [31:0] retire_inst,
  input  logic [31:0] retire_pc,
  input  logic [31:0] a0_value,
  input  logic        illegal_inst,
  input  logic        overflow,
  output logic        stall,
  output logic        halted,
  output logic [1:0]  trap_code,
  output logic [31:0] halt_pc,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  drain_cnt;
  logic [31:0] last_pc;
  logic        in_run, bad, is_ebreak, trap_ev, timeout;

  assign in_run    = (state == S_RUN);
  assign bad       = illegal_inst || overflow;
  assign is_ebreak = (retire_inst == EBREAK_INST);
  assign trap_ev   = in_run && retire_valid && (bad || is_ebreak);
  assign stall     = !in_run;
  assign halted    = (state == S_HALTED);

  wdog_cnt #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (in_run),
    .clr    (retire_valid),
    .expire (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (trap_ev || timeout) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_cnt == DRAIN_LAST) state_nxt = S_HALTED;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  // Capture and counters only move in RUN, so the first trap is the one kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_code   <= TRAP_NONE;
      halt_pc     <= 32'd0;
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
      last_pc     <= 32'd0;
      drain_cnt   <= 4'd0;
    end else if (in_run) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      drain_cnt <= 4'd0;
      if (retire_valid) begin
        instret_cnt <= instret_cnt + 32'd1;
        last_pc     <= retire_pc;
      end
      if (trap_ev) begin
        halt_pc   <= retire_pc;
        trap_code <= trap_classify(bad, a0_value);
      end else if (timeout) begin
        halt_pc   <= last_pc;
        trap_code <= TRAP_TIMEOUT;
      end
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_halt_ctrl.sv
// tb/tb_halt_ctrl.sv - directed vector and sequence bench for halt_ctrl
module tb_halt_ctrl;

  localparam logic [31:0] ADDI   = 32'h00100093;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire_valid;
  logic [31:0] retire_inst, retire_pc, a0_value;
  logic        illegal_inst, overflow;
  logic        stall, halted;
  logic [1:0]  trap_code;
  logic [31:0] halt_pc, cycle_cnt, instret_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  halt_ctrl #(.WDOG_LIMIT(32'd8), .DRAIN_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .retire_valid (retire_valid),
    .retire_inst  (retire_inst),
    .retire_pc    (retire_pc),
    .a0_value     (a0_value),
    .illegal_inst (illegal_inst),
    .overflow     (overflow),
    .stall        (stall),
    .halted       (halted),
    .trap_code    (trap_code),
    .halt_pc      (halt_pc),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  typedef struct {
    logic        rv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] a0;
    logic        ill;
    logic        ovf;
    logic [1:0]  code;
    logic [31:0] hpc;
    logic [31:0] icnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] a0, input logic ill, input logic ovf);
    retire_valid = rv;
    retire_inst  = inst;
    retire_pc    = pc;
    a0_value     = a0;
    illegal_inst = ill;
    overflow     = ovf;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"},   32'(stall), 32'd0);
    chk({tag, ".halted"},  32'(halted), 32'd0);
    chk({tag, ".code"},    32'(trap_code), 32'd0);
    chk({tag, ".hpc"},     halt_pc, 32'd0);
    chk({tag, ".cycles"},  cycle_cnt, 32'd0);
    chk({tag, ".instret"}, instret_cnt, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, EBREAK, 32'h100, 32'd0, 1'b0, 1'b0, 2'b01, 32'h100, 32'd1};
    vecs[1] = '{1'b1, EBREAK, 32'h104, 32'd5, 1'b0, 1'b0, 2'b10, 32'h104, 32'd1};
    vecs[2] = '{1'b1, EBREAK, 32'h108, 32'd0, 1'b0, 1'b1, 2'b10, 32'h108, 32'd1};
    vecs[3] = '{1'b1, ADDI,   32'h10c, 32'd0, 1'b1, 1'b0, 2'b10, 32'h10c, 32'd1};
    vecs[4] = '{1'b1, ADDI,   32'h110, 32'd0, 1'b0, 1'b1, 2'b10, 32'h110, 32'd1};
    vecs[5] = '{1'b1, ADDI,   32'h114, 32'd0, 1'b0, 1'b0, 2'b00, 32'h0,   32'd1};
    vecs[6] = '{1'b0, EBREAK, 32'h118, 32'd0, 1'b1, 1'b0, 2'b00, 32'h0,   32'd0};

    rst = 1'b1;
    idle();

    for (int i = 0; i < 7; i++) begin
      do_reset();
      chk_zero($sformatf("v%0d.reset", i));
      drive(vecs[i].rv, vecs[i].inst, vecs[i].pc, vecs[i].a0, vecs[i].ill, vecs[i].ovf);
      cyc();
      idle();
      chk($sformatf("v%0d.code", i),    32'(trap_code), 32'(vecs[i].code));
      chk($sformatf("v%0d.hpc", i),     halt_pc, vecs[i].hpc);
      chk($sformatf("v%0d.instret", i), instret_cnt, vecs[i].icnt);
      chk($sformatf("v%0d.stall", i),   32'(stall), 32'(vecs[i].code != 2'b00));
      cyc();
      chk($sformatf("v%0d.halt_early", i), 32'(halted), 32'd0);
      cyc();
      chk($sformatf("v%0d.halted", i), 32'(halted), 32'(vecs[i].code != 2'b00));
    end

    // Good trap after three addi; DRAIN retires and HALTED inputs are ignored.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, ADDI, 32'h80000000 + 32'(4 * k), 32'd0, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b1, EBREAK, 32'h80000010, 32'd0, 1'b0, 1'b0);
    cyc();
    chk("good.code", 32'(trap_code), 32'd1);
    chk("good.hpc", halt_pc, 32'h80000010);
    chk("good.instret", instret_cnt, 32'd4);
    chk("good.cycles", cycle_cnt, 32'd4);
    chk("good.halt1", 32'(halted), 32'd0);
    drive(1'b1, ADDI, 32'h80000014, 32'd0, 1'b1, 1'b0);
    cyc();
    chk("good.halt2", 32'(halted), 32'd0);
    chk("good.drain_instret", instret_cnt, 32'd4);
    cyc();
    chk("good.halt3", 32'(halted), 32'd1);
    drive(1'b1, EBREAK, 32'h80000020, 32'd7, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cyc();
    chk("good.hold_halted", 32'(halted), 32'd1);
    chk("good.hold_code", 32'(trap_code), 32'd1);
    chk("good.hold_hpc", halt_pc, 32'h80000010);
    chk("good.hold_instret", instret_cnt, 32'd4);
    chk("good.hold_cycles", cycle_cnt, 32'd4);
    chk("good.hold_stall", 32'(stall), 32'd1);

    // Watchdog expiry after the last retire.
    do_reset();
    drive(1'b1, ADDI, 32'h80000004, 32'd0, 1'b0, 1'b0);
    cyc();
    idle();
    for (int k = 0; k < 7; k++) cyc();
    chk("wdog.pre_stall", 32'(stall), 32'd0);
    chk("wdog.pre_code", 32'(trap_code), 32'd0);
    cyc();
    chk("wdog.code", 32'(trap_code), 32'd3);
    chk("wdog.hpc", halt_pc, 32'h80000004);
    chk("wdog.stall", 32'(stall), 32'd1);
    cyc();
    cyc();
    chk("wdog.halted", 32'(halted), 32'd1);

    // Retire on the expiry cycle rearms the watchdog.
    do_reset();
    drive(1'b1, ADDI, 32'h80000040, 32'd0, 1'b0, 1'b0);
    cyc();
    idle();
    for (int k = 0; k < 7; k++) cyc();
    drive(1'b1, ADDI, 32'h80000044, 32'd0, 1'b0, 1'b0);
    cyc();
    idle();
    chk("rearm.stall", 32'(stall), 32'd0);
    chk("rearm.code", 32'(trap_code), 32'd0);
    for (int k = 0; k < 7; k++) cyc();
    chk("rearm.pre_stall", 32'(stall), 32'd0);
    cyc();
    chk("rearm.code2", 32'(trap_code), 32'd3);
    chk("rearm.hpc", halt_pc, 32'h80000044);

    // Timeout with no retire at all reports pc 0.
    do_reset();
    for (int k = 0; k < 8; k++) cyc();
    chk("noret.code", 32'(trap_code), 32'd3);
    chk("noret.hpc", halt_pc, 32'd0);

    // First trap wins over an ebreak on the following cycle.
    do_reset();
    drive(1'b1, ADDI, 32'h80000100, 32'd0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, EBREAK, 32'h80000104, 32'd0, 1'b0, 1'b0);
    cyc();
    idle();
    chk("first.code", 32'(trap_code), 32'd2);
    chk("first.hpc", halt_pc, 32'h80000100);
    chk("first.instret", instret_cnt, 32'd1);

    // Reset mid-DRAIN clears everything, then counting resumes.
    do_reset();
    drive(1'b1, EBREAK, 32'h80000200, 32'd0, 1'b0, 1'b0);
    cyc();
    idle();
    chk("mid.stall_pre", 32'(stall), 32'd1);
    rst = 1'b1;
    drive(1'b1, EBREAK, 32'h80000300, 32'd1, 1'b1, 1'b1);
    cyc();
    rst = 1'b0;
    chk_zero("mid.reset");
    drive(1'b1, ADDI, 32'h80000400, 32'd0, 1'b0, 1'b0);
    cyc();
    idle();
    chk("mid.cycles", cycle_cnt, 32'd1);
    chk("mid.instret", instret_cnt, 32'd1);
    chk("mid.stall", 32'(stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 Parameter WDOG_LIMIT, default 32'd4096, cycles without a retire before a timeout halt.
REQ-002 Parameter DRAIN_CYCLES, default 2, cycles spent in DRAIN before HALTED (legal range 1..15).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 retire_valid  in  1  one instruction retires this cycle.
REQ-006 retire_inst  in  32  encoding of the retiring instruction.
REQ-007 retire_pc  in  32  PC of the retiring instruction.
REQ-008 a0_value  in  32  current x10 value, sampled with retire_valid.
REQ-009 illegal_inst  in  1  decoder flags the retiring instruction illegal; qualified by retire_valid.
REQ-010 overflow  in  1  ALU overflow on the retiring instruction; qualified by retire_valid.
REQ-011 stall  out  1  freezes PC update and register writeback.
REQ-012 halted  out  1  simulation end reached; the testbench samples it to call $finish.
REQ-013 trap_code  out  2  00 none, 01 good, 10 bad, 11 timeout.
REQ-014 halt_pc  out  32  PC of the trapping instruction; for a timeout, PC of the last retire.
REQ-015 cycle_cnt  out  32  cycles spent in RUN.
REQ-016 instret_cnt  out  32  instructions retired in RUN, including the trapping one.

Function
REQ-017 The FSM SHALL have exactly three states: RUN, DRAIN, HALTED.
REQ-018 Trap event in RUN: retire_valid=1 and any of the following.
- Bad: illegal_inst=1 or overflow=1.
- Ebreak: retire_inst==32'h00100073.
REQ-019 Ebreak code: 01 if a0_value==0, else 10.
REQ-020 Priority: bad SHALL beat ebreak; a bad flag on an ebreak yields 10.
REQ-021 On a trap event:
- capture retire_pc into halt_pc and set trap_code;
- move to DRAIN at the next edge;
- instret_cnt counts the trapping instruction.
REQ-022 stall SHALL be combinationally 1 in DRAIN and HALTED, and 0 in RUN.
REQ-023 DRAIN counter:
- loads 0 on DRAIN entry and increments each DRAIN cycle;
- after DRAIN_CYCLES cycles in DRAIN, the FSM moves to HALTED;
- halted rises exactly DRAIN_CYCLES+1 edges after the trapping retire edge.
REQ-024 HALTED SHALL be absorbing until rst.
- halted, trap_code and halt_pc stay stable.
- All inputs are ignored.
REQ-025 Watchdog counter:
- clears on any retire_valid in RUN, otherwise increments;
- on reaching WDOG_LIMIT-1 with no retire that cycle, sets trap_code=11 and halt_pc to the last retired PC (0 if none), then enters DRAIN.
REQ-026 A retire in the same cycle the watchdog would expire SHALL clear the watchdog; no timeout occurs.
REQ-027 Counter behaviour:
- cycle_cnt and instret_cnt increment only in RUN;
- both wrap modulo 2^32;
- both freeze in DRAIN and HALTED.
REQ-028 Retires arriving in DRAIN SHALL be ignored: no counting and no second capture.
REQ-029 The first trap event SHALL win; later events never overwrite trap_code or halt_pc.

Reset
REQ-030 With rst=1 at an edge, the block SHALL enter RUN and clear to 0:
- stall, halted, trap_code, halt_pc;
- cycle_cnt, instret_cnt;
- watchdog, DRAIN counter, last-PC register.
REQ-031 Reset SHALL take precedence over all events, including mid-DRAIN and in HALTED.
REQ-032 With rst=1, inputs SHALL be ignored.

Structure
REQ-033 A shared package npc_pkg SHALL hold:
- the state encoding localparams;
- the trap_code constants TRAP_NONE/GOOD/BAD/TIMEOUT;
- the EBREAK_INST constant 32'h00100073.
REQ-034 One sub-module, wdog_cnt, SHALL implement the clearable, enabled, terminal-count watchdog; everything else is flat.

Verification
REQ-035 Good trap: retire addi×3 then ebreak at pc=0x80000010 with a0=0.
- trap_code=01, halt_pc=0x80000010, instret_cnt=4;
- halted rises 3 edges after the ebreak (DRAIN_CYCLES=2).
REQ-036 Bad ebreak: ebreak with a0=5 -> trap_code=10.
REQ-037 Overflow and ebreak in the same retire -> trap_code=10.
REQ-038 Watchdog: WDOG_LIMIT=8, last retire pc=0x80000004, then idle.
- trap_code=11 and halt_pc=0x80000004.
- Retire on the expiry cycle -> no halt.
REQ-039 Priority and precedence:
- illegal_inst in cycle N and ebreak in cycle N+1 -> trap_code=10, halt_pc from cycle N;
- rst asserted mid-DRAIN -> all outputs 0 next edge, counting resumes.
